// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch constants: address width, reset vector default,
// instruction increment and alignment-check width.
package riscv_pkg;

  localparam int          XLEN                 = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          INSN_BYTES           = 4;
  localparam int          ALIGN_W              = 2;

endpackage

// File: rtl/pc_incr.sv
// Sequential-successor adder: pc + INSN_BYTES, wrapping modulo 2^XLEN.
module pc_incr
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  // Carry-out is intentionally dropped so the top of the address space wraps to 0.
  assign pc_plus4 = pc + XLEN'(INSN_BYTES);

endmodule

// File: rtl/pc_reg.sv
// Fetch-stage program counter: loads pc_next every cycle, exposes the
// successor address, a post-reset valid flag and a misalignment flag.
module pc_reg
  import riscv_pkg::*;
#(
  parameter int             XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            pc_misaligned
);

  logic [XLEN-1:0] pc_p0;
  logic            vld_p0;

  // Stage 0: PC register; rst is active-low and asynchronous so an unknown
  // pc_next cannot leak into the register while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0  <= RESET_VECTOR;
      vld_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_next;
      vld_p0 <= 1'b1;
    end
  end

  pc_incr #(
    .XLEN (XLEN)
  ) u_pc_incr (
    .pc       (pc_p0),
    .pc_plus4 (pc_plus4)
  );

  assign pc_current    = pc_p0;
  assign pc_valid      = vld_p0;
  assign pc_misaligned = |pc_p0[ALIGN_W-1:0];

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: reset hold, release, sequencing, wrap,
// asynchronous mid-cycle reset and a non-zero reset vector.
module tb_pc_reg;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic [31:0] pc_current, pc_plus4;
  logic        pc_valid, pc_misaligned;
  logic [31:0] rv_current, rv_plus4;
  logic        rv_valid, rv_misaligned;

  int tests;
  int fails;

  pc_reg u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_next       (pc_next),
    .pc_current    (pc_current),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .pc_misaligned (pc_misaligned)
  );

  pc_reg #(
    .RESET_VECTOR (32'h8000_0000)
  ) u_dut_rv (
    .clk           (clk),
    .rst           (rst),
    .pc_next       (pc_next),
    .pc_current    (rv_current),
    .pc_plus4      (rv_plus4),
    .pc_valid      (rv_valid),
    .pc_misaligned (rv_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst     = 1'b0;
    pc_next = 'x;
    #100;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) pc_next = 32'h0000_0001;
      #7;
      tests++;
      if (pc_current !== 32'h0) begin
        fails++;
        $display("FAIL reset_pc[%0d]: got %h expected %h", i, pc_current, 32'h0);
      end
      tests++;
      if (pc_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_valid[%0d]: got %b expected 0", i, pc_valid);
      end
      tests++;
      if (pc_plus4 !== 32'h4) begin
        fails++;
        $display("FAIL reset_plus4[%0d]: got %h expected %h", i, pc_plus4, 32'h4);
      end
      tests++;
      if (pc_misaligned !== 1'b0) begin
        fails++;
        $display("FAIL reset_misaligned[%0d]: got %b expected 0", i, pc_misaligned);
      end
    end
  endtask

  task automatic test_reset_vector();
    tests++;
    if (rv_current !== 32'h8000_0000) begin
      fails++;
      $display("FAIL rv_pc: got %h expected %h", rv_current, 32'h8000_0000);
    end
    tests++;
    if (rv_plus4 !== 32'h8000_0004) begin
      fails++;
      $display("FAIL rv_plus4: got %h expected %h", rv_plus4, 32'h8000_0004);
    end
    tests++;
    if (rv_valid !== 1'b0 || rv_misaligned !== 1'b0) begin
      fails++;
      $display("FAIL rv_flags: got valid=%b mis=%b expected 0 0", rv_valid, rv_misaligned);
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    pc_next = 32'h0000_0001;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (pc_current !== 32'h1) begin
      fails++;
      $display("FAIL release_pc: got %h expected %h", pc_current, 32'h1);
    end
    tests++;
    if (pc_valid !== 1'b1) begin
      fails++;
      $display("FAIL release_valid: got %b expected 1", pc_valid);
    end
    tests++;
    if (pc_misaligned !== 1'b1) begin
      fails++;
      $display("FAIL release_misaligned: got %b expected 1", pc_misaligned);
    end
    tests++;
    if (pc_plus4 !== 32'h5) begin
      fails++;
      $display("FAIL release_plus4: got %h expected %h", pc_plus4, 32'h5);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] vec [3];
    logic [31:0] exp4 [3];
    vec  = '{32'h100, 32'h104, 32'h200};
    exp4 = '{32'h104, 32'h108, 32'h204};
    for (int i = 0; i < 3; i++) begin
      pc_next = vec[i];
      #2;
      tests++;
      if (pc_current === vec[i]) begin
        fails++;
        $display("FAIL seq_latency[%0d]: got %h expected previous value", i, pc_current);
      end
      @(posedge clk);
      #1;
      tests++;
      if (pc_current !== vec[i] || pc_plus4 !== exp4[i]) begin
        fails++;
        $display("FAIL seq[%0d]: got pc=%h plus4=%h expected pc=%h plus4=%h",
                 i, pc_current, pc_plus4, vec[i], exp4[i]);
      end
      tests++;
      if (pc_misaligned !== 1'b0 || pc_valid !== 1'b1) begin
        fails++;
        $display("FAIL seq_flags[%0d]: got mis=%b valid=%b expected 0 1", i, pc_misaligned, pc_valid);
      end
    end
  endtask

  task automatic test_wrap();
    pc_next = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    tests++;
    if (pc_current !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000) begin
      fails++;
      $display("FAIL wrap: got pc=%h plus4=%h expected pc=%h plus4=%h",
               pc_current, pc_plus4, 32'hFFFF_FFFC, 32'h0);
    end
  endtask

  task automatic test_async_reset();
    pc_next = 32'h200;
    @(posedge clk);
    #1;
    tests++;
    if (pc_current !== 32'h200) begin
      fails++;
      $display("FAIL async_pre: got %h expected %h", pc_current, 32'h200);
    end
    pc_next = 32'h300;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (pc_current !== 32'h0 || pc_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_immediate: got pc=%h valid=%b expected pc=%h valid=0",
               pc_current, pc_valid, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (pc_current !== 32'h0 || pc_valid !== 1'b0 || pc_plus4 !== 32'h4) begin
      fails++;
      $display("FAIL async_hold: got pc=%h valid=%b plus4=%h expected %h 0 %h",
               pc_current, pc_valid, pc_plus4, 32'h0, 32'h4);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_reset_vector();
    test_release();
    test_sequence();
    test_wrap();
    test_async_reset();
    test_reset_vector();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
- Program-counter register at the head of the RISC-V fetch stage.
- Holds the address of the instruction currently being fetched.
- Loads the next-PC value computed by fetch/branch logic on every rising clock edge.
- Provides the sequential successor address, a fetch-valid indication and a misalignment flag to downstream fetch logic.

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000 (XLEN bits), value loaded while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = run.
- pc_next  input  XLEN  address to load on the next rising edge.
- pc_current  output  XLEN  registered current PC.
- pc_plus4  output  XLEN  pc_current + 4, combinational.
- pc_valid  output  1  registered; 1 once at least one post-reset load has occurred.
- pc_misaligned  output  1  combinational; 1 when pc_current[1:0] != 2'b00.

Behaviour:
- Interface: one clock domain (clk); rst is asynchronous and active-low.
- Reset assertion (rst falls to 0):
  - pc_current = RESET_VECTOR immediately, without waiting for a clock edge.
  - pc_valid = 0.
  - Outputs hold these values for as long as rst = 0, whatever pc_next does (X/unknown on pc_next is permitted and must not propagate).
- Reset release: synchronous in effect. The first rising clk edge with rst = 1 performs the first load.
- Normal operation: every rising edge with rst = 1:
  - pc_current <= pc_next, latency 1 cycle.
  - pc_valid <= 1.
  - No enable/stall input: the register loads every cycle. Stalling is done upstream by feeding pc_next = pc_current.
- Reset mid-operation: an asynchronous rst = 0 at any time overrides everything. pc_current returns to RESET_VECTOR and pc_valid to 0 within the same delta, not on a clock edge.
- pc_plus4:
  - Unsigned XLEN-bit addition; carry-out discarded, so it wraps modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000).
  - Follows pc_current, including during reset (RESET_VECTOR + 4).
- pc_misaligned:
  - Pure function of pc_current[1:0]; no compressed-ISA support.
  - The register still loads misaligned values unchanged; trapping is the consumer's job.
  - During reset it reflects RESET_VECTOR[1:0] (0 for the default).
- No X on any output after reset assertion.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN
  - RESET_VECTOR default
  - INSN_BYTES = 4 (increment constant)
  - the alignment mask width (2)
- One sub-module is natural: pc_incr, a combinational XLEN-bit adder producing pc_plus4 with wrap.
- The register, valid flag and misalignment check stay in pc_reg.

Test Plan:
- Hold rst = 0 for 100 ns with pc_next = X, then set pc_next = 32'h0000_0001 while still in reset -> pc_current = 32'h0, pc_valid = 0, pc_plus4 = 32'h4, pc_misaligned = 0 throughout.
- Release rst = 1 with pc_next = 32'h0000_0001 -> on the first rising edge pc_current = 32'h1, pc_valid = 1, pc_misaligned = 1, pc_plus4 = 32'h5.
- Drive pc_next sequence 32'h100, 32'h104, 32'h200 on consecutive edges -> pc_current follows one cycle later; pc_plus4 = 32'h104, 32'h108, 32'h204; pc_misaligned = 0.
- pc_next = 32'hFFFF_FFFC -> pc_current = 32'hFFFF_FFFC, pc_plus4 = 32'h0000_0000.
- Assert rst = 0 mid-cycle (between edges) while pc_current = 32'h200 -> pc_current = RESET_VECTOR and pc_valid = 0 immediately, before the next edge; both hold until release.
- Override RESET_VECTOR = 32'h8000_0000 -> during reset pc_current = 32'h8000_0000, pc_plus4 = 32'h8000_0004.
